// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED position bar: state and direction encodings,
// LED index width, the sweep position payload and the bounce step helper.
package led_ctrl_pkg;

    localparam int unsigned LED_W  = 4;
    localparam int unsigned MODE_W = 2;

    localparam logic [LED_W-1:0] LED_MAX = 4'd15;

    // Encodings visible on o_Mode
    localparam logic [MODE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [MODE_W-1:0] ST_SWEEP = 2'd1;
    localparam logic [MODE_W-1:0] ST_HOLD  = 2'd2;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Sweep position: current index plus travel direction
    typedef struct packed {
        logic             dir;
        logic [LED_W-1:0] value;
    } sweep_pos_t;

    // One sweep step; the ends reflect so the index never wraps
    function automatic sweep_pos_t bounce_step(input sweep_pos_t cur);
        sweep_pos_t nxt;
        nxt = cur;
        if (cur.dir == DIR_UP) begin
            if (cur.value == LED_MAX) begin
                nxt.dir   = DIR_DOWN;
                nxt.value = LED_MAX - LED_W'(1);
            end else begin
                nxt.value = cur.value + LED_W'(1);
            end
        end else begin
            if (cur.value == '0) begin
                nxt.dir   = DIR_UP;
                nxt.value = LED_W'(1);
            end else begin
                nxt.value = cur.value - LED_W'(1);
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/led_position_sched_if.sv
// Command/status bundle between the UART decoder, the scheduler and the bar driver.
//   master: drives i_Cmd_Valid, i_Cmd_Value, i_Sweep_En; observes the outputs
//   slave : the scheduler; drives o_LED_Value, o_Mode, o_Step_Tick
interface led_position_sched_if;
    import led_ctrl_pkg::*;

    logic                    i_Cmd_Valid;
    logic [LED_W-1:0]        i_Cmd_Value;
    logic                    i_Sweep_En;
    logic [LED_W-1:0]        o_LED_Value;
    logic [MODE_W-1:0]       o_Mode;
    logic                    o_Step_Tick;

    modport master (
        output i_Cmd_Valid, i_Cmd_Value, i_Sweep_En,
        input  o_LED_Value, o_Mode, o_Step_Tick
    );

    modport slave (
        input  i_Cmd_Valid, i_Cmd_Value, i_Sweep_En,
        output o_LED_Value, o_Mode, o_Step_Tick
    );

endinterface

// File: rtl/led_position_sched_step_timer.sv
// Free-running step timer: counts 0..CLKS_PER_STEP-1 and wraps.
//   i_Clk, i_Rst_n : clock, async active-low reset
//   o_Tick         : high during the cycle in which the counter wraps
module step_timer #(
    parameter int unsigned CLKS_PER_STEP = 2_500_000
) (
    input  logic i_Clk,
    input  logic i_Rst_n,
    output logic o_Tick
);

    localparam int unsigned        CNT_W = $clog2(CLKS_PER_STEP);
    localparam logic [CNT_W-1:0]   LAST  = CNT_W'(CLKS_PER_STEP - 1);

    logic [CNT_W-1:0] cnt;

    // Wrap counter, never restarted except by reset
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Combinational so the sequencer acts on the wrap edge itself
    assign o_Tick = (cnt == LAST);

endmodule

// File: rtl/led_position_sched.sv
// LED position sequencer: arbitrates the bar index between position commands
// and an autonomous bounce sweep, with commanded positions held for HOLD_STEPS ticks.
//   i_Clk, i_Rst_n : clock, async active-low reset
//   bus (slave)    : command inputs, sweep enable, LED index / mode / step tick outputs
module led_position_sched
    import led_ctrl_pkg::*;
#(
    parameter int unsigned CLKS_PER_STEP = 2_500_000,
    parameter int unsigned HOLD_STEPS    = 20
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_n,
    led_position_sched_if.slave   bus
);

    localparam int unsigned       HOLD_W    = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);

    logic              tick;
    logic [MODE_W-1:0] state_q, state_d;
    sweep_pos_t        pos_q, pos_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              step_tick_q;

    step_timer #(
        .CLKS_PER_STEP (CLKS_PER_STEP)
    ) u_step_timer (
        .i_Clk   (i_Clk),
        .i_Rst_n (i_Rst_n),
        .o_Tick  (tick)
    );

    // State, position/direction, hold count and tick output registers
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q     <= ST_IDLE;
            pos_q       <= '{dir: DIR_UP, value: '0};
            hold_q      <= '0;
            step_tick_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            hold_q      <= hold_d;
            step_tick_q <= tick;
        end
    end

    // Next state: a command beats everything; sweep disable beats a coincident tick
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        hold_d  = hold_q;
        if (bus.i_Cmd_Valid) begin
            state_d     = ST_HOLD;
            pos_d.value = bus.i_Cmd_Value;
            hold_d      = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.i_Sweep_En) begin
                        state_d = ST_SWEEP;
                    end
                end
                ST_SWEEP: begin
                    if (!bus.i_Sweep_En) begin
                        state_d = ST_IDLE;
                    end else if (tick) begin
                        pos_d = bounce_step(pos_q);
                    end
                end
                ST_HOLD: begin
                    if (tick) begin
                        if (hold_q == HOLD_LAST) begin
                            hold_d  = '0;
                            state_d = bus.i_Sweep_En ? ST_SWEEP : ST_IDLE;
                        end else begin
                            hold_d = hold_q + HOLD_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_LED_Value = pos_q.value;
    assign bus.o_Mode      = state_q;
    assign bus.o_Step_Tick = step_tick_q;

endmodule

// File: doc/led_position_sched.md
# led_position_sched

Sequencer for the 16-LED one-hot position bar. Arbitrates the 4-bit LED index between Bluetooth-decoded position commands and an autonomous bounce sweep, and paces sweep steps and command hold time from a step timer. Sits between the UART command decoder and the LED bar driver, whose 4-bit index input it feeds.

## Interface
Parameters:
- CLKS_PER_STEP, 2_500_000: i_Clk cycles per step tick (≥2)
- HOLD_STEPS, 20: step ticks a commanded position is held before the sweep resumes (≥1)

Ports:
- i_Clk  in  1  system clock; all logic on rising edge
- i_Rst_n  in  1  reset, asynchronous assert, active-low
- i_Cmd_Valid  in  1  one-cycle pulse: i_Cmd_Value is a new position command
- i_Cmd_Value  in  4  commanded LED index 0..15
- i_Sweep_En  in  1  level: allow the autonomous sweep
- o_LED_Value  out  4  registered LED index to the bar driver
- o_Mode  out  2  registered state: 0 IDLE, 1 SWEEP, 2 HOLD
- o_Step_Tick  out  1  registered one-cycle pulse on each step-timer wrap

## Operation
- Reset values: state IDLE, o_LED_Value 0, o_Mode 0, o_Step_Tick 0, direction UP, step counter 0, hold counter 0.
- Step timer: free-running, counts 0..CLKS_PER_STEP-1, wraps to 0. Tick is asserted in the cycle the counter wraps. It runs in every state and is never restarted by commands.
- Command priority: i_Cmd_Valid wins over every other event in the same cycle, in any state.
  - Next cycle: state HOLD, o_LED_Value = i_Cmd_Value, hold counter 0.
  - Direction is unchanged.
  - A command arriving during HOLD restarts the hold.
- IDLE:
  - o_LED_Value is frozen.
  - i_Sweep_En=1 moves to SWEEP next cycle. No value change until the next tick.
- SWEEP, on tick, value steps by direction with bounce:
  - UP and 15: direction becomes DOWN, value 14.
  - DOWN and 0: direction becomes UP, value 1.
  - Otherwise ±1.
  - i_Sweep_En=0 moves to IDLE next cycle with the value frozen. This takes precedence over a coincident tick.
- HOLD, on tick:
  - If hold counter = HOLD_STEPS-1, leave HOLD: to SWEEP if i_Sweep_En=1, else IDLE. The value is unchanged on the exit cycle; the sweep continues from the held value in the current direction.
  - Otherwise increment the hold counter.
- Values are 4-bit; no wrap-around arithmetic is ever used. Bounce handles the ends.

## Timing
- Command to o_LED_Value: 1 cycle. The bar driver adds 1 more, so 2 cycles to the LED pin.
- o_Step_Tick is registered and lags the internal tick by 1 cycle. The first pulse is at cycle CLKS_PER_STEP after reset release.
- Hold duration: HOLD_STEPS full ticks after the command if the command lands mid-interval. The first counted tick is the first one after the command cycle.
- Mid-operation reset clears everything asynchronously. Outputs read reset values while i_Rst_n is low; operation resumes on the first edge after release.

## Structure
- Shared package/include `led_ctrl_pkg`:
  - state encodings IDLE/SWEEP/HOLD
  - direction encoding UP=0/DOWN=1
  - LED_MAX=15, LED index width 4
- Sub-module `step_timer`:
  - parameter CLKS_PER_STEP
  - ports i_Clk, i_Rst_n, o_Tick
  - counter width $clog2(CLKS_PER_STEP)
- Top holds the FSM, direction flag, hold counter and output registers.

## Test plan
Bench uses CLKS_PER_STEP=4, HOLD_STEPS=3.
- Reset, i_Sweep_En=1, no commands, run 40 ticks -> o_LED_Value 0,1,…,15,14,…,0,1,… on successive ticks; o_Mode=1.
- i_Cmd_Valid with value 9 while sweeping at 4 -> next cycle o_LED_Value=9, o_Mode=2. It stays 9 for 3 ticks, then returns to SWEEP and steps from 9 in the prior direction.
- i_Cmd_Valid coincident with a SWEEP tick at value 15 -> value = command, not 14. A second command during HOLD restarts the hold count.
- i_Sweep_En=0 during HOLD with value 6 -> after 3 ticks o_Mode=0, o_LED_Value stays 6 indefinitely. Re-enabling gives o_Mode=1, then 7 at the next tick.
- Assert i_Rst_n=0 mid-sweep at value 11 going DOWN -> o_LED_Value=0 and o_Mode=0 immediately, without waiting for a clock edge. After release the direction is UP.
- i_Sweep_En dropped on the same cycle as a tick -> IDLE, value unchanged.
